fetch_pc_unit: RTL

Parametrised next-generation program counter for the fetch front end. It generalises the plain PC+4 / PC+imm register in four ways:
- configurable width, reset vector and alignment;
- valid/ready handshake to the instruction-fetch stage;
- prioritised redirects (trap, PC-relative branch/JAL, register-based JALR);
- a halt/resume FSM and misaligned-target detection.

It sits between the control/execute redirect sources and instruction memory.

---
 rtl/fetch_pc_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter for the fetch front end: sequential advance, prioritised trap/branch/JALR redirects, halt/resume FSM, misaligned-target rejection.
// Latency: one cycle from any input to pc/pc_valid/halted/misalign_*; pc_plus is combinational from pc.
// Backpressure: pc and pc_valid hold while pc_valid & !pc_ready, except that a trap or an accepted redirect flushes pc.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   redirect_*          taken branch/jump: kind 0 = base+imm, kind 1 = JALR (base+imm, bit0 cleared)
//   trap_valid/_vector  highest-priority redirect, never alignment-checked
//   halt_req, resume    level halt request, resume pulse out of HALTED
//   pc_valid/pc_ready   handshake to instruction fetch; pc_plus = pc + INC
//   halted              FSM is in HALTED
//   misalign_err/_addr  one-cycle pulse and captured target of a rejected redirect
module fetch_pc_unit #(
    parameter int                 XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_VECTOR = '0,
    parameter int                 INC          = 4,
    parameter int                 ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic            redirect_kind,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_imm,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            pc_ready,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            halted,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr
);

    localparam logic [XLEN-1:0] ONE        = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
    // Low bits that must be zero in a redirect target; all-zero mask when ALIGN_BITS = 0.
    localparam logic [XLEN-1:0] ALIGN_MASK = (ONE << ALIGN_BITS) - ONE;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state;
    logic            fire;
    logic            active;
    logic [XLEN-1:0] rel_sum;
    logic [XLEN-1:0] target;
    logic            target_misaligned;
    logic            redirect_take;
    logic            misalign_hit;
    logic [XLEN-1:0] pc_next;

    // Sums wrap modulo 2^XLEN; carries are simply dropped.
    assign pc_plus = pc + INC_W;

    always_comb begin
        fire              = pc_valid & pc_ready;
        active            = (state != BOOT);
        rel_sum           = redirect_base + redirect_imm;
        target            = redirect_kind ? {rel_sum[XLEN-1:1], 1'b0} : rel_sum;
        target_misaligned = |(target & ALIGN_MASK);
        redirect_take     = redirect_valid & ~target_misaligned;
        // A concurrent trap overrides the redirect entirely, so it also masks the error.
        misalign_hit      = active & redirect_valid & ~trap_valid & target_misaligned;

        pc_next = pc;
        if (trap_valid) begin
            pc_next = trap_vector;
        end else if (redirect_take) begin
            pc_next = target;
        end else if (fire) begin
            pc_next = pc_plus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= BOOT;
            pc            <= RESET_VECTOR;
            pc_valid      <= 1'b0;
            halted        <= 1'b0;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_err <= 1'b0;

            // BOOT ignores every input; the PC only starts moving once running.
            if (active) begin
                pc <= pc_next;
                if (misalign_hit) begin
                    misalign_err  <= 1'b1;
                    misalign_addr <= target;
                end
            end

            // Redirects never alter the state; only the handshake and halt/resume do.
            unique case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (halt_req) begin
                        if (fire || !pc_valid) begin
                            state    <= HALTED;
                            pc_valid <= 1'b0;
                            halted   <= 1'b1;
                        end else begin
                            // Offered PC must be consumed before fetch stops.
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fire) begin
                        state    <= HALTED;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end
                end
                HALTED: begin
                    if (resume && !halt_req) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule
